// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, decode and the regfile
// write port. The arbiter connects through the slave modport; drivers use master.
interface wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic                flush;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                alu_valid;
  logic                alu_ready;
  logic [AW-1:0]       alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                lsu_valid;
  logic                lsu_ready;
  logic [AW-1:0]       lsu_rd;
  logic [XLEN-1:0]     lsu_data;
  logic                we;
  logic [AW-1:0]       writeaddr;
  logic [XLEN-1:0]     writedata;
  logic [(2**AW)-1:0]  busy;
  logic                err_orphan;

  modport slave (
    input  flush, issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output we, writeaddr, writedata, busy, err_orphan
  );

  modport master (
    output flush, issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  we, writeaddr, writedata, busy, err_orphan
  );
endinterface

// File: rtl/wb_arbiter.sv
// Arbitrates ALU and LSU results onto the single regfile write port and keeps
// the per-register busy scoreboard. Define WB_LOAD_PRIORITY_EN for fixed LSU priority.
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);
  localparam int NREG = 2**AW;

  logic            alu_grant, lsu_grant, xfer, wr_nz;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;
`ifndef WB_LOAD_PRIORITY_EN
  // 1 = LSU was granted last, 0 = ALU
  logic            rr_last_q, rr_last_d;
`endif

  always_comb begin
`ifdef WB_LOAD_PRIORITY_EN
    lsu_grant = !bus.flush && bus.lsu_valid;
    alu_grant = !bus.flush && bus.alu_valid && !bus.lsu_valid;
`else
    alu_grant = !bus.flush && bus.alu_valid && (!bus.lsu_valid || rr_last_q);
    lsu_grant = !bus.flush && bus.lsu_valid && (!bus.alu_valid || !rr_last_q);
`endif
    xfer     = alu_grant || lsu_grant;
    sel_rd   = alu_grant ? bus.alu_rd   : bus.lsu_rd;
    sel_data = alu_grant ? bus.alu_data : bus.lsu_data;
    // Writes to x0 complete the handshake but never reach the regfile
    wr_nz    = xfer && (sel_rd != '0);

    we_d    = wr_nz;
    waddr_d = wr_nz ? sel_rd   : waddr_q;
    wdata_d = wr_nz ? sel_data : wdata_q;
    err_d   = err_q || (wr_nz && !busy_q[sel_rd]);

    busy_d = busy_q;
    if (wr_nz)
      busy_d[sel_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0))
      busy_d[bus.issue_rd] = 1'b1;
    if (bus.flush)
      busy_d = '0;
`ifndef WB_LOAD_PRIORITY_EN
    rr_last_d = xfer ? lsu_grant : rr_last_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
`ifndef WB_LOAD_PRIORITY_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifndef WB_LOAD_PRIORITY_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign bus.alu_ready  = alu_grant;
  assign bus.lsu_ready  = lsu_grant;
  assign bus.we         = we_q;
  assign bus.writeaddr  = waddr_q;
  assign bus.writedata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.err_orphan = err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed cycle table, reset corner, then random traffic
// against a rule-level reference model.
module tb_wb_arbiter;
`ifdef WB_LOAD_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();
  wb_arbiter #(.XLEN(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        fl, iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ear, elr, ewe;
    logic [4:0]  eaddr;
    logic [31:0] edata, ebusy;
    logic        eerr;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [4:0] ird,
                              input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                              input logic ear, input logic elr, input logic ewe,
                              input logic [4:0] eaddr, input logic [31:0] edata,
                              input logic [31:0] ebusy, input logic eerr);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.ear = ear; v.elr = elr; v.ewe = ewe;
    v.eaddr = eaddr; v.edata = edata; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.flush = fl; bus.issue_valid = iv; bus.issue_rd = ird;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ldat;
  endtask

  // reference model state
  logic        m_we, m_err, m_last_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_busy;
  logic        ap, lp, fl, iv, ga, gl;
  logic [4:0]  ard, lrd, ird, rd;
  logic [31:0] adat, ldat, d;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(0,1,5, 0,0,0,            0,0,0,      0,0, 0,0,0,        32'h20, 0);
    tbl[1]  = mk(0,0,0, 1,5,32'hAA,       0,0,0,      1,0, 1,5,32'hAA,   32'h0,  0);
    tbl[2]  = mk(0,0,0, 0,0,0,            0,0,0,      0,0, 0,5,32'hAA,   32'h0,  0);
    tbl[3]  = mk(0,1,3, 0,0,0,            0,0,0,      0,0, 0,5,32'hAA,   32'h08, 0);
    tbl[4]  = mk(0,1,4, 0,0,0,            0,0,0,      0,0, 0,5,32'hAA,   32'h18, 0);
    tbl[5]  = mk(0,0,0, 1,3,32'h11,       1,4,32'h22, 0,1, 1,4,32'h22,   32'h08, 0);
    tbl[6]  = mk(0,0,0, 1,3,32'h11,       0,0,0,      1,0, 1,3,32'h11,   32'h0,  0);
    tbl[7]  = mk(0,1,4, 0,0,0,            0,0,0,      0,0, 0,3,32'h11,   32'h10, 0);
    tbl[8]  = mk(0,0,0, 0,0,0,            1,4,32'h33, 0,1, 1,4,32'h33,   32'h0,  0);
    tbl[9]  = mk(0,1,3, 0,0,0,            0,0,0,      0,0, 0,4,32'h33,   32'h08, 0);
    tbl[10] = mk(0,1,4, 0,0,0,            0,0,0,      0,0, 0,4,32'h33,   32'h18, 0);
    tbl[11] = mk(0,0,0, 1,3,32'h11,       1,4,32'h22, !PRIO,PRIO, 1,
                 PRIO ? 5'd4 : 5'd3, PRIO ? 32'h22 : 32'h11, PRIO ? 32'h08 : 32'h10, 0);
    tbl[12] = mk(0,0,0, PRIO,3,32'h11,    !PRIO,4,32'h22, PRIO,!PRIO, 1,
                 PRIO ? 5'd3 : 5'd4, PRIO ? 32'h11 : 32'h22, 32'h0, 0);
    tbl[13] = mk(0,0,0, 1,0,32'hFFFF_FFFF, 0,0,0,     1,0, 0,
                 PRIO ? 5'd3 : 5'd4, PRIO ? 32'h11 : 32'h22, 32'h0, 0);
    tbl[14] = mk(0,1,7, 0,0,0,            0,0,0,      0,0, 0,
                 PRIO ? 5'd3 : 5'd4, PRIO ? 32'h11 : 32'h22, 32'h80, 0);
    tbl[15] = mk(0,1,7, 1,7,32'h77,       0,0,0,      1,0, 1,7,32'h77,   32'h80, 0);
    tbl[16] = mk(0,0,0, 0,0,0,            1,9,32'h99, 0,1, 1,9,32'h99,   32'h80, 1);
    tbl[17] = mk(0,0,0, 0,0,0,            0,0,0,      0,0, 0,9,32'h99,   32'h80, 1);
    tbl[18] = mk(0,1,1, 0,0,0,            0,0,0,      0,0, 0,9,32'h99,   32'h82, 1);
    tbl[19] = mk(0,1,2, 0,0,0,            0,0,0,      0,0, 0,9,32'h99,   32'h86, 1);
    tbl[20] = mk(1,1,5, 1,1,32'h05,       0,0,0,      0,0, 0,9,32'h99,   32'h0,  1);
    tbl[21] = mk(0,0,0, 1,1,32'h05,       0,0,0,      1,0, 1,1,32'h05,   32'h0,  1);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_we",    {31'b0, bus.we},         0);
    chk("rst_addr",  {27'b0, bus.writeaddr},  0);
    chk("rst_data",  bus.writedata,           0);
    chk("rst_busy",  bus.busy,                0);
    chk("rst_err",   {31'b0, bus.err_orphan}, 0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ird, tbl[i].av, tbl[i].ard, tbl[i].adat,
            tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
      #1;
      chk($sformatf("t%0d_alu_ready", i), {31'b0, bus.alu_ready}, {31'b0, tbl[i].ear});
      chk($sformatf("t%0d_lsu_ready", i), {31'b0, bus.lsu_ready}, {31'b0, tbl[i].elr});
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_we", i),   {31'b0, bus.we},         {31'b0, tbl[i].ewe});
      chk($sformatf("t%0d_addr", i), {27'b0, bus.writeaddr},  {27'b0, tbl[i].eaddr});
      chk($sformatf("t%0d_data", i), bus.writedata,           tbl[i].edata);
      chk($sformatf("t%0d_busy", i), bus.busy,                tbl[i].ebusy);
      chk($sformatf("t%0d_err", i),  {31'b0, bus.err_orphan}, {31'b0, tbl[i].eerr});
    end

    // asynchronous reset landing in a we=1 cycle
    @(negedge clk);
    drive(0, 1, 6, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 6, 32'h66, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_we", {31'b0, bus.we}, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_we",   {31'b0, bus.we},         0);
    chk("arst_addr", {27'b0, bus.writeaddr},  0);
    chk("arst_data", bus.writedata,           0);
    chk("arst_busy", bus.busy,                0);
    chk("arst_err",  {31'b0, bus.err_orphan}, 0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic against the reference model
    m_we = 0; m_err = 0; m_last_lsu = 1; m_addr = 0; m_data = 0; m_busy = 0;
    ap = 0; lp = 0; ard = 0; lrd = 0; adat = 0; ldat = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!ap && $urandom_range(0, 1) == 1) begin
        ap = 1; ard = 5'($urandom_range(0, 15)); adat = $urandom;
      end
      if (!lp && $urandom_range(0, 1) == 1) begin
        lp = 1; lrd = 5'($urandom_range(0, 15)); ldat = $urandom;
      end
      fl  = ($urandom_range(0, 15) == 0);
      iv  = ($urandom_range(0, 1) == 1);
      ird = 5'($urandom_range(0, 15));
      drive(fl, iv, ird, ap, ard, adat, lp, lrd, ldat);

      ga = 0; gl = 0;
      if (!fl) begin
        if (PRIO) begin
          gl = lp; ga = ap && !lp;
        end else if (ap && lp) begin
          ga = m_last_lsu; gl = !m_last_lsu;
        end else begin
          ga = ap; gl = lp;
        end
      end
      #1;
      chk("rnd_alu_ready", {31'b0, bus.alu_ready}, {31'b0, ga});
      chk("rnd_lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, gl});

      @(posedge clk);
      m_we = 0;
      if (ga || gl) begin
        rd = ga ? ard : lrd;
        d  = ga ? adat : ldat;
        if (rd != 0) begin
          m_we = 1; m_addr = rd; m_data = d;
          if (!m_busy[rd]) m_err = 1;
          m_busy[rd] = 0;
        end
        m_last_lsu = gl;
        if (ga) ap = 0; else lp = 0;
      end
      if (iv && ird != 0) m_busy[ird] = 1;
      if (fl) m_busy = 0;
      #1;
      chk("rnd_we",   {31'b0, bus.we},         {31'b0, m_we});
      chk("rnd_addr", {27'b0, bus.writeaddr},  {27'b0, m_addr});
      chk("rnd_data", bus.writedata,           m_data);
      chk("rnd_busy", bus.busy,                m_busy);
      chk("rnd_err",  {31'b0, bus.err_orphan}, {31'b0, m_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
